// File: rtl/sgd_weight_update_pkg.sv
// sgd_pkg: shared types, Q16.16 constants and the saturate-or-wrap helper
// used by the SGD weight-update stage and its fixed-point multiplier.
// Optional feature macro: SGD_SAT_EN (saturating arithmetic instead of wrap).
package sgd_pkg;

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_RD_G = 3'd1,
    S_RD_W = 3'd2,
    S_EX   = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int          FRAC_BITS = 16;
  localparam logic [31:0] Q_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_MIN     = 32'h8000_0000;

  // Reduce a wide signed value to Q16.16: clamp to the representable range
  // when SGD_SAT_EN is defined, otherwise keep the low 32 bits (wrap).
  function automatic logic [31:0] sat_or_wrap(input logic signed [63:0] x);
    logic [31:0] r;
`ifdef SGD_SAT_EN
    if (x > 64'sh0000_0000_7FFF_FFFF) begin
      r = Q_MAX;
    end else if (x < 64'shFFFF_FFFF_8000_0000) begin
      r = Q_MIN;
    end else begin
      r = x[31:0];
    end
`else
    r = x[31:0];
`endif
    return r;
  endfunction

endpackage

// File: rtl/sgd_weight_update_if.sv
// Start/done handshake plus single memory port of the SGD weight-update stage.
// slave = the update block itself, master = sequencer and memory side.
interface sgd_weight_update_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic              go;
  logic              done;
  logic [ADDR_W-1:0] grad_base;
  logic [ADDR_W-1:0] w_base;
  logic [CNT_W-1:0]  count;
  logic [31:0]       lr;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  go, grad_base, w_base, count, lr, mem_rdata, mem_ack,
    output done, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output go, grad_base, w_base, count, lr, mem_rdata, mem_ack,
    input  done, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sgd_weight_update_fxp_mul_q16.sv
// fxp_mul_q16: combinational signed Q16.16 multiply. The 64-bit product is
// arithmetic-shifted right by 16 (floor rounding) and reduced to 32 bits,
// saturating when SGD_SAT_EN is defined, wrapping otherwise.
module fxp_mul_q16
  import sgd_pkg::*;
(
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic        [31:0] p
);

  logic signed [63:0] prod_s;
  logic signed [63:0] shifted_s;

  // Full-precision product, drop the fractional bits, then narrow.
  always_comb begin
    prod_s    = 64'sd0;
    shifted_s = 64'sd0;
    prod_s    = a * b;
    shifted_s = prod_s >>> FRAC_BITS;
    p         = sat_or_wrap(shifted_s);
  end

endmodule

// File: rtl/sgd_weight_update.sv
// sgd_weight_update: streams gradient/weight pairs through one memory port,
// computes w' = w - lr*g in Q16.16 and writes w' back in place.
// Optional feature macro: SGD_SAT_EN (saturate p and w' instead of wrapping).
module sgd_weight_update
  import sgd_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_l,
  sgd_weight_update_if.slave bus
);

  state_t            state_r;
  logic [CNT_W-1:0]  idx_r;
  logic [ADDR_W-1:0] grad_base_r;
  logic [ADDR_W-1:0] w_base_r;
  logic [CNT_W-1:0]  count_r;
  logic [31:0]       lr_r;
  logic [31:0]       g_r;
  logic [31:0]       w_r;
  logic              done_r;
  logic              req_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;

  logic [31:0]        p_s;
  logic signed [32:0] diff_s;
  logic [31:0]        w_new_s;
  logic               last_s;
  logic [CNT_W-1:0]   idx_next_s;

  fxp_mul_q16 u_mul (
    .a (lr_r),
    .b (g_r),
    .p (p_s)
  );

  // 33-bit subtraction so the out-of-range case is visible before narrowing.
  always_comb begin
    diff_s     = $signed({w_r[31], w_r}) - $signed({p_s[31], p_s});
    w_new_s    = sat_or_wrap({{31{diff_s[32]}}, diff_s});
    last_s     = (idx_r == (count_r - CNT_W'(1)));
    idx_next_s = idx_r + CNT_W'(1);
  end

  // Control FSM; every memory-port output is a register held until its ack.
  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      state_r     <= S_WAIT;
      idx_r       <= '0;
      grad_base_r <= '0;
      w_base_r    <= '0;
      count_r     <= '0;
      lr_r        <= 32'h0000_0000;
      g_r         <= 32'h0000_0000;
      w_r         <= 32'h0000_0000;
      done_r      <= 1'b0;
      req_r       <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_WAIT: begin
          if (bus.go) begin
            grad_base_r <= bus.grad_base;
            w_base_r    <= bus.w_base;
            count_r     <= bus.count;
            lr_r        <= bus.lr;
            idx_r       <= '0;
            if (bus.count == '0) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_RD_G;
              req_r   <= 1'b1;
              we_r    <= 1'b0;
              addr_r  <= bus.grad_base;
            end
          end
        end
        S_RD_G: begin
          if (bus.mem_ack) begin
            g_r     <= bus.mem_rdata;
            state_r <= S_RD_W;
            addr_r  <= w_base_r + ADDR_W'(idx_r);
          end
        end
        S_RD_W: begin
          if (bus.mem_ack) begin
            w_r     <= bus.mem_rdata;
            state_r <= S_EX;
            req_r   <= 1'b0;
          end
        end
        S_EX: begin
          wdata_r <= w_new_s;
          req_r   <= 1'b1;
          we_r    <= 1'b1;
          addr_r  <= w_base_r + ADDR_W'(idx_r);
          state_r <= S_WB;
        end
        S_WB: begin
          if (bus.mem_ack) begin
            we_r <= 1'b0;
            if (last_s) begin
              req_r   <= 1'b0;
              done_r  <= 1'b1;
              state_r <= S_DONE;
            end else begin
              idx_r   <= idx_next_s;
              addr_r  <= grad_base_r + ADDR_W'(idx_next_s);
              state_r <= S_RD_G;
            end
          end
        end
        S_DONE: begin
          if (!bus.go) begin
            done_r  <= 1'b0;
            state_r <= S_WAIT;
          end
        end
        default: begin
          state_r <= S_WAIT;
          done_r  <= 1'b0;
          req_r   <= 1'b0;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done      = done_r;
  assign bus.mem_req   = req_r;
  assign bus.mem_we    = we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;

endmodule

// File: tb/tb_sgd_weight_update.sv
// Directed bench for sgd_weight_update: table of single-element updates plus
// hand-written sequences for vectors, wait states, count = 0 and mid-run reset.
// Expected values honour SGD_SAT_EN the same way the design build does.
module tb_sgd_weight_update;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    logic [31:0] lr;
    logic [31:0] g;
    logic [31:0] w;
    logic [31:0] exp_w;
  } vec_t;

  logic clk;
  logic rst_l;

  sgd_weight_update_if bus ();

  sgd_weight_update dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  // memory model: img preloaded by the test, wmem holds DUT writes
  logic [31:0] img   [0:65535];
  logic [31:0] wmem  [0:65535];
  logic        wvalid[0:65535];
  int          delay;
  int          wcnt;
  acc_t        acc_log[$];
  int          viol;
  logic        prev_pend;
  logic        prev_we;
  logic [15:0] prev_addr;
  logic [31:0] prev_wdata;

  int n_cmp;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_ack   = bus.mem_req && (wcnt == delay);
  assign bus.mem_rdata = wvalid[bus.mem_addr] ? wmem[bus.mem_addr] : img[bus.mem_addr];

  always @(posedge clk or posedge rst_l) begin
    if (rst_l) wcnt <= 0;
    else if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  initial begin
    viol = 0;
    prev_pend = 1'b0;
    for (int k = 0; k < 65536; k++) wvalid[k] = 1'b0;
  end

  always @(negedge clk) begin
    if (prev_pend && (!bus.mem_req || bus.mem_we !== prev_we ||
        bus.mem_addr !== prev_addr || bus.mem_wdata !== prev_wdata))
      viol = viol + 1;
    prev_pend  = bus.mem_req && !bus.mem_ack && !rst_l;
    prev_we    = bus.mem_we;
    prev_addr  = bus.mem_addr;
    prev_wdata = bus.mem_wdata;
    if (bus.mem_req && bus.mem_ack && !rst_l) begin
      acc_log.push_back({bus.mem_we, bus.mem_addr, bus.mem_wdata});
      if (bus.mem_we) begin
        wmem[bus.mem_addr]   = bus.mem_wdata;
        wvalid[bus.mem_addr] = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [15:0] a);
    return wvalid[a] ? wmem[a] : img[a];
  endfunction

  // start a run, scramble inputs after the sampling edge, count cycles to done
  task automatic run(input logic [15:0] gb, input logic [15:0] wb,
                     input logic [15:0] cnt, input logic [31:0] l, output int cyc);
    @(negedge clk);
    bus.grad_base = gb;
    bus.w_base    = wb;
    bus.count     = cnt;
    bus.lr        = l;
    bus.go        = 1'b1;
    @(posedge clk);
    #1;
    bus.grad_base = 16'hDEAD;
    bus.w_base    = 16'hBEEF;
    bus.count     = 16'h0007;
    bus.lr        = 32'h1234_5678;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic drop_go();
    @(negedge clk);
    bus.go = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[5];
  int   cyc;
  int   base;
  int   v0;
  int   found;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    delay  = 0;
    rst_l  = 1'b1;
    bus.go = 1'b0;
    bus.grad_base = 16'h0000;
    bus.w_base    = 16'h0000;
    bus.count     = 16'h0000;
    bus.lr        = 32'h0000_0000;

    tbl[0] = '{32'h0000_8000, 32'h0002_0000, 32'h0003_0000, 32'h0002_0000};
    tbl[2] = '{32'h0000_8000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
`ifdef SGD_SAT_EN
    tbl[1] = '{32'h0001_0000, 32'hFFFE_0000, 32'h7FFF_0000, 32'h7FFF_FFFF};
    tbl[3] = '{32'h0001_0000, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000};
    tbl[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0001};
`else
    tbl[1] = '{32'h0001_0000, 32'hFFFE_0000, 32'h7FFF_0000, 32'h8001_0000};
    tbl[3] = '{32'h0001_0000, 32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF};
    tbl[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0001_0000};
`endif

    for (int k = 0; k < 65536; k++) img[k] = 32'h0000_0000;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.done}, 64'd0);
    @(negedge clk);
    rst_l = 1'b0;

    // single-element table
    for (int i = 0; i < 5; i++) begin
      img[16'h0010 + i] = tbl[i].g;
      img[16'h0020 + i] = tbl[i].w;
      base = acc_log.size();
      run(16'h0010 + 16'(i), 16'h0020 + 16'(i), 16'h0001, tbl[i].lr, cyc);
      chk($sformatf("vec%0d_done_cycle", i), 64'(cyc), 64'd5);
      chk($sformatf("vec%0d_weight", i), 64'(rd(16'h0020 + 16'(i))), 64'(tbl[i].exp_w));
      chk($sformatf("vec%0d_accesses", i), 64'(acc_log.size() - base), 64'd3);
      drop_go();
      chk($sformatf("vec%0d_done_low", i), 64'(bus.done), 64'd0);
    end

    // vector of 4
    for (int i = 0; i < 4; i++) img[16'h0200 + i] = 32'h0005_0000;
    img[16'h0100] = 32'h0001_0000;
    img[16'h0101] = 32'h0002_0000;
    img[16'h0102] = 32'hFFFF_0000;
    img[16'h0103] = 32'h0000_0000;
    base = acc_log.size();
    run(16'h0100, 16'h0200, 16'h0004, 32'h0001_0000, cyc);
    chk("vec4_done_cycle", 64'(cyc), 64'd17);
    chk("vec4_w0", 64'(rd(16'h0200)), 64'h0004_0000);
    chk("vec4_w1", 64'(rd(16'h0201)), 64'h0003_0000);
    chk("vec4_w2", 64'(rd(16'h0202)), 64'h0006_0000);
    chk("vec4_w3", 64'(rd(16'h0203)), 64'h0005_0000);
    chk("vec4_nacc", 64'(acc_log.size() - base), 64'd12);
    if (acc_log.size() - base == 12) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("vec4_order_g%0d", i), 64'({acc_log[base+3*i].we, acc_log[base+3*i].addr}),
            64'({1'b0, 16'h0100 + 16'(i)}));
        chk($sformatf("vec4_order_w%0d", i), 64'({acc_log[base+3*i+1].we, acc_log[base+3*i+1].addr}),
            64'({1'b0, 16'h0200 + 16'(i)}));
        chk($sformatf("vec4_order_wr%0d", i), 64'({acc_log[base+3*i+2].we, acc_log[base+3*i+2].addr}),
            64'({1'b1, 16'h0200 + 16'(i)}));
      end
    end
    drop_go();

    // wait states on every access
    delay = 3;
    v0 = viol;
    img[16'h0300] = 32'h0001_0000;
    img[16'h0301] = 32'h0002_0000;
    img[16'h0400] = 32'h0005_0000;
    img[16'h0401] = 32'h0005_0000;
    run(16'h0300, 16'h0400, 16'h0002, 32'h0001_0000, cyc);
    chk("wait_done_cycle", 64'(cyc), 64'd27);
    chk("wait_stability", 64'(viol - v0), 64'd0);
    chk("wait_w0", 64'(rd(16'h0400)), 64'h0004_0000);
    chk("wait_w1", 64'(rd(16'h0401)), 64'h0003_0000);
    drop_go();
    delay = 0;

    // count = 0 and go held across DONE
    base = acc_log.size();
    run(16'h0700, 16'h0800, 16'h0000, 32'h0001_0000, cyc);
    chk("cnt0_done_cycle", 64'(cyc), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("cnt0_done_held", 64'(bus.done), 64'd1);
    drop_go();
    chk("cnt0_done_low", 64'(bus.done), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("cnt0_no_access", 64'(acc_log.size() - base), 64'd0);

    // reset during the weight read of the second element
    for (int i = 0; i < 3; i++) begin
      img[16'h0500 + i] = 32'h0001_0000;
      img[16'h0600 + i] = 32'h0005_0000;
    end
    @(negedge clk);
    bus.grad_base = 16'h0500;
    bus.w_base    = 16'h0600;
    bus.count     = 16'h0003;
    bus.lr        = 32'h0001_0000;
    bus.go        = 1'b1;
    found = 0;
    for (int t = 0; t < 100 && found == 0; t++) begin
      @(negedge clk);
      if (bus.mem_req && !bus.mem_we && bus.mem_addr == 16'h0601) found = 1;
    end
    chk("rstmid_reached_rdw", 64'(found), 64'd1);
    #2;
    rst_l  = 1'b1;
    bus.go = 1'b0;
    #1;
    chk("rstmid_outputs", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.done}, 64'd0);
    @(negedge clk);
    rst_l = 1'b0;
    base = acc_log.size();
    run(16'h0500, 16'h0600, 16'h0003, 32'h0001_0000, cyc);
    chk("rstmid_done_cycle", 64'(cyc), 64'd13);
    if (acc_log.size() > base)
      chk("rstmid_first_access", 64'({acc_log[base].we, acc_log[base].addr}), 64'({1'b0, 16'h0500}));
    else
      chk("rstmid_first_access", 64'(acc_log.size() - base), 64'd1);
    chk("rstmid_w0", 64'(rd(16'h0600)), 64'h0003_0000);
    chk("rstmid_w1", 64'(rd(16'h0601)), 64'h0004_0000);
    chk("rstmid_w2", 64'(rd(16'h0602)), 64'h0004_0000);
    drop_go();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sgd_weight_update.md
# sgd_weight_update

Weight-update stage directly downstream of the convolution backward unit. Once backward has written a gradient tensor to memory, this block streams gradient/weight pairs through one memory port, computes w' = w − lr·g in Q16.16 fixed point, and writes w' back in place. It is started by the training-loop sequencer with the same go/done handshake as the other FPU stages.

## Interface
- ADDR_W, 16, memory word-address width
- CNT_W, 16, element-count width
- clk  input  1  clock; all state changes on its rising edge
- rst_l  input  1  reset, asynchronous and active-high; the block is in reset while rst_l = 1
- go  input  1  start request, sampled in WAIT
- done  output  1  high while in DONE
- grad_base  input  ADDR_W  gradient tensor base address, latched on start
- w_base  input  ADDR_W  weight tensor base address, latched on start
- count  input  CNT_W  number of elements, latched on start
- lr  input  32  learning rate, Q16.16, latched on start
- mem_req  output  1  memory request; held until mem_ack
- mem_we  output  1  1 = write, 0 = read; valid while mem_req = 1
- mem_addr  output  ADDR_W  request address
- mem_wdata  output  32  write data
- mem_rdata  input  32  read data; valid in the mem_ack cycle of a read
- mem_ack  input  1  request complete; may be asserted in the same cycle as mem_req

## Operation
- States: WAIT, RD_G, RD_W, EX, WB, DONE.
- WAIT: if go = 1, latch the inputs, clear idx, and go to RD_G; if count = 0, go straight to DONE instead.
- RD_G: read at grad_base+idx. On mem_ack, capture g and go to RD_W.
- RD_W: read at w_base+idx. On mem_ack, capture w and go to EX.
- EX: compute p = (lr × g) as a 64-bit signed product, arithmetic-shifted right by 16, rounded toward −∞. Then compute w' = w − p using a 33-bit signed intermediate, reduced per Configuration. Register w', then go to WB.
- WB: write w' to w_base+idx. On mem_ack:
  - if idx = count−1, go to DONE;
  - otherwise increment idx and go to RD_G.
- DONE: stay in DONE while go = 1; return to WAIT when go = 0.
- Address arithmetic wraps modulo 2^ADDR_W. Overlapping grad/weight regions are not checked.
- Inputs that change after start are ignored until the next start.

## Timing
- Reset values:
  - state = WAIT, done = 0;
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0;
  - idx and all latched registers = 0.
- Reset asserted mid-operation aborts immediately. An outstanding request is dropped, and the memory side must tolerate a withdrawn req.
- mem_req, mem_we, mem_addr and mem_wdata are registered (or decoded from registered state) and stay stable until the ack cycle.
- mem_req is low in WAIT, EX and DONE.
- With zero-wait memory (ack in the same cycle), each element takes 4 cycles (RD_G, RD_W, EX, WB). done rises 4·count+1 cycles after the go-sampling edge. With count = 0, done rises 1 cycle after.
- Each cycle of ack delay adds one cycle per affected access.
- go held high across DONE does not restart the block; a new run needs a low-then-high go.

## Configuration
- SGD_SAT_EN defined: w' saturates to 0x7FFFFFFF / 0x80000000 when the 33-bit intermediate is out of range. The shifted product p saturates the same way before subtraction.
- SGD_SAT_EN undefined: p and w' are truncated to their low 32 bits (two's-complement wrap).

## Structure
- Package sgd_pkg holds:
  - the state enum;
  - Q16.16 constants FRAC_BITS = 16, Q_MAX = 32'h7FFF_FFFF, Q_MIN = 32'h8000_0000;
  - a saturate-or-wrap function shared with EX.
- One sub-module, fxp_mul_q16: a combinational signed 32×32 multiply with >>>16 and optional saturation under SGD_SAT_EN, reusable by other FPU stages.

## Test plan
- Basic update: lr = 0x00008000, g = 0x00020000, w = 0x00030000, count = 1, zero-wait memory → write 0x00020000 to w_base; done 5 cycles after go.
- Vector of 4, grad_base = 0x0100, w_base = 0x0200, lr = 0x00010000, g = {1,2,−1,0}·0x10000, w all 0x00050000 → weights {0x40000, 0x30000, 0x60000, 0x50000}; access order G0,W0,WR0,G1,… ; done at cycle 17.
- Overflow: lr = 0x00010000, g = 0xFFFE0000, w = 0x7FFF0000 → 0x7FFFFFFF with SGD_SAT_EN, 0x80010000 without.
- Wait states: mem_ack delayed 3 cycles on every access, count = 2 → addresses and wdata held stable throughout; done at cycle 2·(4+9)+1 = 27.
- count = 0 → no mem_req ever; done 1 cycle after go; held while go = 1, back to WAIT on go = 0.
- Reset mid-run: assert rst_l during RD_W of element 2 → all outputs return to reset values asynchronously; a fresh go after release processes from idx 0.
